// File: rtl/datapath_control_sequencer_pkg.sv
// Shared definitions for the datapath control sequencer: opcodes, FSM states,
// instruction field positions and FLAGS bit indices.
package datapath_pkg;

    localparam logic [2:0] OP_MOV = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_LDI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int DA_MSB  = 12;
    localparam int DA_LSB  = 10;
    localparam int AA_MSB  = 9;
    localparam int AA_LSB  = 7;
    localparam int BA_MSB  = 6;
    localparam int BA_LSB  = 4;
    localparam int IMM_MSB = 6;
    localparam int IMM_LSB = 0;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/datapath_control_sequencer_if.sv
// Instruction handshake plus register file port bundle between the sequencer
// (master) and its instruction source / register file (slave).
interface datapath_control_sequencer_if #(
    parameter int WORD_WIDTH = 16
);
    logic [15:0]           INSTR;
    logic                  INSTR_VALID;
    logic                  INSTR_READY;
    logic [2:0]            AA;
    logic [2:0]            BA;
    logic [WORD_WIDTH-1:0] A_Data;
    logic [WORD_WIDTH-1:0] B_Data;
    logic [2:0]            DA;
    logic [WORD_WIDTH-1:0] D_Data;
    logic                  RW;
    logic [3:0]            FLAGS;
    logic                  BUSY;

    modport master (
        input  INSTR, INSTR_VALID, A_Data, B_Data,
        output INSTR_READY, AA, BA, DA, D_Data, RW, FLAGS, BUSY
    );

    modport slave (
        output INSTR, INSTR_VALID, A_Data, B_Data,
        input  INSTR_READY, AA, BA, DA, D_Data, RW, FLAGS, BUSY
    );
endinterface

// File: rtl/datapath_control_sequencer_function_unit.sv
// Combinational function unit: evaluates one opcode on the captured operands
// and derives {V, C, N, Z} from the truncated result.
module datapath_function_unit
    import datapath_pkg::*;
#(
    parameter int WORD_WIDTH = 16
) (
    input  logic [2:0]            opcode,
    input  logic [WORD_WIDTH-1:0] opa,
    input  logic [WORD_WIDTH-1:0] opb,
    input  logic [6:0]            imm,
    output logic [WORD_WIDTH-1:0] result,
    output logic [3:0]            flags
);
    localparam int MSB = WORD_WIDTH - 1;

    logic [WORD_WIDTH:0]   sum;
    logic [WORD_WIDTH-1:0] diff;
    logic                  carry;
    logic                  ovf;

    assign sum  = {1'b0, opa} + {1'b0, opb};
    assign diff = opa - opb;

    // For SUB, C means "no borrow", i.e. opa >= opb unsigned.
    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (opcode)
            OP_MOV: result = opa;
            OP_ADD: begin
                result = sum[MSB:0];
                carry  = sum[WORD_WIDTH];
                ovf    = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]);
            end
            OP_SUB: begin
                result = diff;
                carry  = (opa >= opb);
                ovf    = (opa[MSB] != opb[MSB]) && (diff[MSB] != opa[MSB]);
            end
            OP_AND: result = opa & opb;
            OP_OR:  result = opa | opb;
            OP_XOR: result = opa ^ opb;
            OP_NOT: result = ~opa;
            OP_LDI: result = {{(WORD_WIDTH-7){1'b0}}, imm};
            default: result = '0;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_N] = result[MSB];
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
    end
endmodule

// File: rtl/datapath_control_sequencer.sv
// Four-state sequencer (IDLE/READ/EXEC/WRITE) that issues one register file
// read, one function evaluation and one write-back per accepted instruction.
module datapath_control_sequencer
    import datapath_pkg::*;
#(
    parameter int WORD_WIDTH = 16
) (
    input logic                         CLK,
    input logic                         RST,
    datapath_control_sequencer_if.master bus
);
    state_t                state;
    logic [15:0]           ir;
    logic [WORD_WIDTH-1:0] opa;
    logic [WORD_WIDTH-1:0] opb;
    logic [WORD_WIDTH-1:0] d_data;
    logic [3:0]            flags;
    logic [WORD_WIDTH-1:0] fu_result;
    logic [3:0]            fu_flags;

    datapath_function_unit #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_fu (
        .opcode (ir[OP_MSB:OP_LSB]),
        .opa    (opa),
        .opb    (opb),
        .imm    (ir[IMM_MSB:IMM_LSB]),
        .result (fu_result),
        .flags  (fu_flags)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            ir     <= '0;
            opa    <= '0;
            opb    <= '0;
            d_data <= '0;
            flags  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.INSTR_VALID) begin
                        ir    <= bus.INSTR;
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    opa   <= bus.A_Data;
                    opb   <= bus.B_Data;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    d_data <= fu_result;
                    flags  <= fu_flags;
                    state  <= ST_WRITE;
                end
                ST_WRITE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Addresses come straight from IR so they hold steady for the whole instruction.
    assign bus.AA          = ir[AA_MSB:AA_LSB];
    assign bus.BA          = ir[BA_MSB:BA_LSB];
    assign bus.DA          = ir[DA_MSB:DA_LSB];
    assign bus.D_Data      = d_data;
    assign bus.FLAGS       = flags;
    assign bus.RW          = (state == ST_WRITE);
    assign bus.BUSY        = (state != ST_IDLE);
    assign bus.INSTR_READY = (state == ST_IDLE) && !RST;
endmodule

// File: tb/tb_datapath_control_sequencer.sv
// Directed, table-driven bench for datapath_control_sequencer with a
// behavioural 8-entry register file attached to its ports.
module tb_datapath_control_sequencer;
    localparam int WORD_WIDTH = 16;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] a_val;
        logic [15:0] b_val;
        logic [2:0]  da;
        logic [15:0] exp_d;
        logic [3:0]  exp_f;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_vec = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   rw_count = 0;

    logic        pl_en = 1'b0;
    logic [2:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [15:0] regs [8];

    vec_t vecs [12];

    always #5 CLK = ~CLK;

    datapath_control_sequencer_if #(.WORD_WIDTH(WORD_WIDTH)) bus ();

    datapath_control_sequencer #(.WORD_WIDTH(WORD_WIDTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Register file model: combinational reads, write on the rising edge.
    assign bus.A_Data = regs[bus.AA];
    assign bus.B_Data = regs[bus.BA];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (bus.RW) rw_count <= rw_count + 1;
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (bus.RW) regs[bus.DA] <= bus.D_Data;
    end

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [15:0] data);
        pl_en   = 1'b1;
        pl_addr = addr;
        pl_data = data;
        @(negedge CLK);
        pl_en   = 1'b0;
    endtask

    task automatic apply_stimulus(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        preload(3'd1, v.a_val);
        preload(3'd2, v.b_val);
        bus.INSTR       = v.instr;
        bus.INSTR_VALID = 1'b1;
        @(negedge CLK);
        bus.INSTR_VALID = 1'b0;
        bus.INSTR       = 16'hFFFF;
        check_output({tag, ".ready_read"}, {15'd0, bus.INSTR_READY}, 16'd0);
        check_output({tag, ".busy_read"}, {15'd0, bus.BUSY}, 16'd1);
        @(negedge CLK);
        check_output({tag, ".rw_exec"}, {15'd0, bus.RW}, 16'd0);
        @(negedge CLK);
        check_output({tag, ".rw_write"}, {15'd0, bus.RW}, 16'd1);
        check_output({tag, ".da"}, {13'd0, bus.DA}, {13'd0, v.da});
        check_output({tag, ".d_data"}, bus.D_Data, v.exp_d);
        check_output({tag, ".flags"}, {12'd0, bus.FLAGS}, {12'd0, v.exp_f});
        @(negedge CLK);
        check_output({tag, ".ready_idle"}, {15'd0, bus.INSTR_READY}, 16'd1);
        check_output({tag, ".regfile"}, regs[v.da], v.exp_d);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] b2b_instr [3];
        logic [15:0] b2b_exp [3];
        logic [2:0]  b2b_da [3];
        int          accept_cyc [3];
        int          rw_before;

        //            instr     R1        R2        DA    D_Data    {V,C,N,Z}
        vecs[0]  = '{16'hEC55, 16'h0000, 16'h0000, 3'd3, 16'h0055, 4'b0000};
        vecs[1]  = '{16'h54A0, 16'h0001, 16'h0002, 3'd5, 16'hFFFF, 4'b0010};
        vecs[2]  = '{16'h5890, 16'h1234, 16'h0002, 3'd6, 16'h0000, 4'b0101};
        vecs[3]  = '{16'h60A0, 16'hF0F0, 16'h3C3C, 3'd0, 16'h3030, 4'b0000};
        vecs[4]  = '{16'h88A0, 16'hF0F0, 16'h3C3C, 3'd2, 16'hFCFC, 4'b0010};
        vecs[5]  = '{16'hACA0, 16'hF0F0, 16'h3C3C, 3'd3, 16'hCCCC, 4'b0010};
        vecs[6]  = '{16'hD080, 16'hF0F0, 16'h3C3C, 3'd4, 16'h0F0F, 4'b0000};
        vecs[7]  = '{16'h1500, 16'hF0F0, 16'h3C3C, 3'd5, 16'h3C3C, 4'b0000};
        vecs[8]  = '{16'h1500, 16'hF0F0, 16'h0000, 3'd5, 16'h0000, 4'b0001};
        vecs[9]  = '{16'h30A0, 16'hFFFF, 16'h0001, 3'd4, 16'h0000, 4'b0101};
        vecs[10] = '{16'h54A0, 16'h8000, 16'h0001, 3'd5, 16'h7FFF, 4'b1100};
        vecs[11] = '{16'h30A0, 16'h7FFF, 16'h0001, 3'd4, 16'h8000, 4'b1010};

        b2b_instr = '{16'h30A0, 16'h54A0, 16'hF812};
        b2b_exp   = '{16'h0003, 16'hFFFF, 16'h0012};
        b2b_da    = '{3'd4, 3'd5, 3'd6};

        bus.INSTR       = 16'h0000;
        bus.INSTR_VALID = 1'b0;
        RST             = 1'b1;
        repeat (3) @(negedge CLK);
        check_output("rst.ready", {15'd0, bus.INSTR_READY}, 16'd0);
        check_output("rst.busy", {15'd0, bus.BUSY}, 16'd0);
        check_output("rst.rw", {15'd0, bus.RW}, 16'd0);
        check_output("rst.d_data", bus.D_Data, 16'd0);
        check_output("rst.flags", {12'd0, bus.FLAGS}, 16'd0);
        RST = 1'b0;
        #1;
        check_output("rst.ready_after", {15'd0, bus.INSTR_READY}, 16'd1);
        @(negedge CLK);

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Back-to-back acceptance with VALID held high; INSTR is scrambled mid-instruction.
        preload(3'd1, 16'h0001);
        preload(3'd2, 16'h0002);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("b2b%0d.ready_idle", i), {15'd0, bus.INSTR_READY}, 16'd1);
            bus.INSTR       = b2b_instr[i];
            bus.INSTR_VALID = 1'b1;
            @(negedge CLK);
            accept_cyc[i] = cyc;
            bus.INSTR = 16'hFFFF;
            if (i == 2) bus.INSTR_VALID = 1'b0;
            check_output($sformatf("b2b%0d.ready_read", i), {15'd0, bus.INSTR_READY}, 16'd0);
            @(negedge CLK);
            check_output($sformatf("b2b%0d.ready_exec", i), {15'd0, bus.INSTR_READY}, 16'd0);
            @(negedge CLK);
            check_output($sformatf("b2b%0d.ready_write", i), {15'd0, bus.INSTR_READY}, 16'd0);
            check_output($sformatf("b2b%0d.da", i), {13'd0, bus.DA}, {13'd0, b2b_da[i]});
            check_output($sformatf("b2b%0d.d_data", i), bus.D_Data, b2b_exp[i]);
            @(negedge CLK);
            if (i > 0)
                check_output($sformatf("b2b%0d.interval", i), 16'(accept_cyc[i] - accept_cyc[i-1]), 16'd4);
        end
        check_output("b2b.idle_after", {15'd0, bus.BUSY}, 16'd0);

        // Reset lands while ADD R7,R1,R2 is in EXEC; the write must never happen.
        preload(3'd1, 16'h7FFF);
        preload(3'd2, 16'h0001);
        preload(3'd7, 16'hBEEF);
        rw_before       = rw_count;
        bus.INSTR       = 16'h3CA0;
        bus.INSTR_VALID = 1'b1;
        @(negedge CLK);
        bus.INSTR_VALID = 1'b0;
        @(negedge CLK);
        check_output("abort.da_exec", {13'd0, bus.DA}, 16'd7);
        RST = 1'b1;
        @(negedge CLK);
        check_output("abort.rw", {15'd0, bus.RW}, 16'd0);
        check_output("abort.busy", {15'd0, bus.BUSY}, 16'd0);
        check_output("abort.ready_in_rst", {15'd0, bus.INSTR_READY}, 16'd0);
        check_output("abort.aa", {13'd0, bus.AA}, 16'd0);
        check_output("abort.ba", {13'd0, bus.BA}, 16'd0);
        check_output("abort.da", {13'd0, bus.DA}, 16'd0);
        check_output("abort.d_data", bus.D_Data, 16'd0);
        check_output("abort.flags", {12'd0, bus.FLAGS}, 16'd0);
        RST = 1'b0;
        #1;
        check_output("abort.ready_after", {15'd0, bus.INSTR_READY}, 16'd1);
        repeat (4) @(negedge CLK);
        check_output("abort.no_write", 16'(rw_count - rw_before), 16'd0);
        check_output("abort.r7", regs[7], 16'hBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/datapath_control_sequencer.md
# datapath_control_sequencer

Multi-cycle sequencer that drives the read and write ports of the 8x`WORD_WIDTH` datapath register file, acting as its initiator. It accepts one instruction at a time over a valid/ready handshake and performs the register file operations: source addresses, operand capture, function evaluation and a single write-back. It sits between the instruction source and the register file, and owns AA/BA/DA/RW/D_Data.

## Interface
- `WORD_WIDTH`, 16, data word width; equals register file width; must be ≥ 16.
- `CLK`  in  1  sole clock; all state changes on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `INSTR`  in  16  instruction: [15:13] opcode, [12:10] DA, [9:7] AA, [6:4] BA, [6:0] LDI immediate.
- `INSTR_VALID`  in  1  INSTR is valid.
- `INSTR_READY`  out  1  sequencer can accept an instruction.
- `AA`  out  3  register file read address A.
- `BA`  out  3  register file read address B.
- `A_Data`  in  WORD_WIDTH  register file read data A; combinational from AA.
- `B_Data`  in  WORD_WIDTH  register file read data B; combinational from BA.
- `DA`  out  3  register file write address.
- `D_Data`  out  WORD_WIDTH  register file write data.
- `RW`  out  1  register file write enable.
- `FLAGS`  out  4  {V, C, N, Z} from last executed instruction.
- `BUSY`  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE → READ → EXEC → WRITE → IDLE. There are no other transitions except reset.
- IDLE: INSTR_READY=1. On INSTR_VALID & INSTR_READY, latch INSTR into IR and go to READ. If VALID is low, stay in IDLE.
- READ: AA=IR[9:7] and BA=IR[6:4]. Capture A_Data/B_Data into operand registers OPA/OPB, then go to EXEC.
- EXEC: compute result from OPA/OPB per opcode. Latch result into D_Data register and update FLAGS, then go to WRITE.
- WRITE: RW=1 and DA=IR[12:10]. Go to IDLE. RW is high only in WRITE.
- AA/BA/DA are driven from IR in every state. They are therefore stable for the whole instruction.
- Opcodes:
  - 000 MOV: A.
  - 001 ADD: A+B.
  - 010 SUB: A−B.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 NOT: ~A.
  - 111 LDI: zero-extended IR[6:0]. Operands are ignored.
- Arithmetic is modulo 2^WORD_WIDTH; results are truncated to WORD_WIDTH.
- Z = (result==0); N = result MSB.
- ADD: C = carry out of the MSB; V = signed overflow.
- SUB: C = no borrow (A ≥ B unsigned); V = signed overflow.
- All other opcodes clear C and V.
- INSTR changes while not in IDLE are ignored. Only IR is used.

## Timing
- Accept at edge k. Operands captured at k+1. Result and FLAGS at k+2. Register file write at edge k+3.
- INSTR_READY is high again in the cycle after edge k+3. Throughput is 1 instruction per 4 cycles.
- No read-after-write hazard. The next READ occurs no earlier than edge k+5, after the write at k+3.
- AA=BA, or DA equal to a source, are legal and need no special handling.
- RST sampled high at any edge forces the following outputs after that edge:
  - state=IDLE, IR=0, OPA=OPB=0.
  - D_Data=0, FLAGS=0, RW=0.
  - AA=BA=DA=0, BUSY=0.
- While RST is high, INSTR_READY=0. INSTR_READY=1 from the first cycle with RST low.
- Reset mid-instruction aborts it. No write is issued, including when reset hits in EXEC or WRITE: RW is low from the cycle after the reset edge.
- INSTR_VALID held high continuously gives back-to-back acceptance every 4 cycles.

## Structure
- Shared package `datapath_pkg`:
  - opcode localparams.
  - state enum (IDLE, READ, EXEC, WRITE).
  - instruction field bit positions.
  - FLAGS bit indices.
- Sub-module `datapath_function_unit`: purely combinational. It takes opcode, OPA, OPB and immediate, and produces result plus {V,C,N,Z}. It is instantiated once; the sequencer registers its outputs in EXEC.

## Test plan
- Reset then LDI R3,#0x55 (INSTR=0xEC55), with the register file model attached:
  - RW=1, DA=3, D_Data=0x0055 in the 4th cycle after accept.
  - Z=0, N=0.
  - R3 reads 0x0055 afterwards.
- R1=0x7FFF, R2=0x0001, ADD R4,R1,R2 → D_Data=0x8000, V=1, N=1, C=0, Z=0.
- R1=0x0001, R2=0x0002, SUB R5,R1,R2 → D_Data=0xFFFF, C=0, N=1, V=0.
- SUB R6,R1,R1 → D_Data=0, Z=1, C=1.
- INSTR_VALID held high with 3 queued instructions:
  - accepted exactly every 4 cycles.
  - INSTR_READY low in READ/EXEC/WRITE.
  - INSTR changed mid-instruction does not alter DA/D_Data.
- Assert RST during EXEC of ADD R7,R1,R2:
  - RW never asserts and R7 is unchanged.
  - all outputs are at reset values.
  - INSTR_READY=1 in the first cycle after RST falls.
